// File: rtl/dco_pkg.sv
// rtl/dco_pkg.sv - shared DCO constants and controller state type
package dco_pkg;

   localparam int          DCO_NUM_CELLS = 129;
   localparam int          DCO_LEVEL_W   = 8;
   localparam logic [7:0]  DCO_MAX_LEVEL = 8'd129;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SLEW  = 2'd1,
      TRACK = 2'd2
   } dco_ctrl_state_t;

endpackage

// File: rtl/dco_code_ctrl_therm_enc.sv
// rtl/dco_code_ctrl_therm_enc.sv - binary level to 129-cell thermometer decoder
module therm_enc
   import dco_pkg::*;
(
   input  logic [DCO_LEVEL_W-1:0]   level,
   output logic [DCO_NUM_CELLS-1:0] code
);

   // Levels at or above the cell count naturally decode to all-ones.
   always_comb begin
      code = '0;
      for (int i = 0; i < DCO_NUM_CELLS; i++) begin
         code[i] = (i < int'(level));
      end
   end

endmodule

// File: rtl/dco_code_ctrl.sv
// rtl/dco_code_ctrl.sv - slew-limited, fraction-dithered DCO thermometer code driver
module dco_code_ctrl
   import dco_pkg::*;
#(
   parameter int FRAC_W   = 4,
   parameter int MAX_STEP = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tune_valid,
   input  logic [FRAC_W+7:0] tune_word,
   input  logic              freeze,
   output logic [128:0]      code,
   output logic [7:0]        code_level,
   output logic              settled
);

   localparam logic [7:0] STEP = 8'(MAX_STEP);

   dco_ctrl_state_t   state_q, state_d;
   logic [7:0]        tgt_q, tgt_d;
   logic [FRAC_W-1:0] frac_q, frac_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [7:0]        cur_q, cur_d;
   logic [7:0]        code_level_q, code_level_d;
   logic [128:0]      code_q, code_d;
   logic              settled_q, settled_d;
   logic              armed_q, armed_d;

   logic [7:0]        int_lvl, tune_lvl, tgt_eff;
   logic [7:0]        up_diff, dn_diff, slew_lvl, dither_lvl;
   logic [FRAC_W:0]   acc_sum;

   always_comb begin
      int_lvl  = tune_word[FRAC_W+7:FRAC_W];
      tune_lvl = (int_lvl > DCO_MAX_LEVEL) ? DCO_MAX_LEVEL : int_lvl;
      // A fresh tune word steers IDLE/TRACK decisions on the edge it arrives.
      tgt_eff  = tune_valid ? tune_lvl : tgt_q;

      up_diff = tgt_q - cur_q;
      dn_diff = cur_q - tgt_q;
      if (tgt_q > cur_q) begin
         slew_lvl = cur_q + ((up_diff > STEP) ? STEP : up_diff);
      end else begin
         slew_lvl = cur_q - ((dn_diff > STEP) ? STEP : dn_diff);
      end

      acc_sum    = {1'b0, acc_q} + {1'b0, frac_q};
      dither_lvl = (acc_sum[FRAC_W] && (cur_q < DCO_MAX_LEVEL)) ? cur_q + 8'd1 : cur_q;
   end

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      frac_d       = frac_q;
      armed_d      = armed_q;
      cur_d        = cur_q;
      acc_d        = acc_q;
      code_level_d = code_level_q;

      if (tune_valid) begin
         tgt_d   = tune_lvl;
         frac_d  = tune_word[FRAC_W-1:0];
         armed_d = 1'b1;
      end

      if (!freeze) begin
         case (state_q)
            IDLE: begin
               code_level_d = 8'd0;
               // armed_q covers a target that was latched while frozen.
               if (tune_valid || armed_q) begin
                  state_d = (tgt_eff == 8'd0) ? TRACK : SLEW;
               end
            end
            SLEW: begin
               cur_d        = slew_lvl;
               code_level_d = slew_lvl;
               if (slew_lvl == tgt_q) begin
                  state_d = TRACK;
               end
            end
            TRACK: begin
               if (tgt_eff != cur_q) begin
                  state_d      = SLEW;
                  code_level_d = cur_q;
               end else begin
                  acc_d        = acc_sum[FRAC_W-1:0];
                  code_level_d = dither_lvl;
               end
            end
            default: begin
               state_d      = IDLE;
               code_level_d = 8'd0;
            end
         endcase
      end

      settled_d = (state_d == TRACK);
   end

   therm_enc u_therm_enc (
      .level (code_level_d),
      .code  (code_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         tgt_q        <= '0;
         frac_q       <= '0;
         armed_q      <= 1'b0;
         cur_q        <= '0;
         acc_q        <= '0;
         code_level_q <= '0;
         code_q       <= '0;
         settled_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         frac_q       <= frac_d;
         armed_q      <= armed_d;
         cur_q        <= cur_d;
         acc_q        <= acc_d;
         code_level_q <= code_level_d;
         code_q       <= code_d;
         settled_q    <= settled_d;
      end
   end

   assign code       = code_q;
   assign code_level = code_level_q;
   assign settled    = settled_q;

endmodule

// File: tb/tb_dco_code_ctrl.sv
// tb/tb_dco_code_ctrl.sv - directed self-checking bench for dco_code_ctrl
module tb_dco_code_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tune_valid = 1'b0;
   logic [11:0]  tune_word = '0;
   logic         freeze = 1'b0;
   logic [128:0] code;
   logic [7:0]   code_level;
   logic         settled;

   int checks = 0;
   int errors = 0;

   dco_code_ctrl #(.FRAC_W(4), .MAX_STEP(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .tune_valid (tune_valid),
      .tune_word  (tune_word),
      .freeze     (freeze),
      .code       (code),
      .code_level (code_level),
      .settled    (settled)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [128:0] therm(input int l);
      logic [129:0] t;
      t = (130'(1) << l) - 130'(1);
      return t[128:0];
   endfunction

   task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tune(input logic [7:0] lvl, input logic [3:0] fr);
      tune_valid = 1'b1;
      tune_word  = {lvl, fr};
      tick();
      tune_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      int cnt40;
      int cnt41;

      // 1: reset and idle
      tick();
      chk("rst_code", code, 0);
      chk("rst_level", code_level, 0);
      chk("rst_settled", settled, 0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_level", code_level, 0);
         chk("idle_settled", settled, 0);
      end
      chk("idle_code", code, 0);

      // 2: ramp up to 40, then down to 10
      set_tune(8'd40, 4'd0);
      chk("t2_k_level", code_level, 0);
      chk("t2_k_settled", settled, 0);
      for (int n = 1; n <= 5; n++) begin
         tick();
         chk("t2_up_level", code_level, 8 * n);
         chk("t2_up_code", code, therm(8 * n));
         chk("t2_up_settled", settled, (n == 5) ? 1 : 0);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_hold_level", code_level, 40);
      end
      set_tune(8'd10, 4'd0);
      chk("t2_rt_level", code_level, 40);
      chk("t2_rt_settled", settled, 0);
      begin
         int dn[4];
         dn = '{32, 24, 16, 10};
         for (int n = 0; n < 4; n++) begin
            tick();
            chk("t2_dn_level", code_level, dn[n]);
            chk("t2_dn_code", code, therm(dn[n]));
            chk("t2_dn_settled", settled, (n == 3) ? 1 : 0);
         end
      end

      // 3: clamp above 129, then saturated dither at the top
      pulse_reset();
      set_tune(8'd200, 4'd0);
      chk("t3_k_level", code_level, 0);
      for (int n = 1; n <= 16; n++) begin
         tick();
         chk("t3_up_level", code_level, 8 * n);
      end
      tick();
      chk("t3_top_level", code_level, 129);
      chk("t3_top_code", code, therm(129));
      chk("t3_top_settled", settled, 1);
      set_tune(8'd200, 4'd8);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_sat_level", code_level, 129);
         chk("t3_sat_code", code, therm(129));
      end

      // 4: dither 4/16 at level 40
      pulse_reset();
      set_tune(8'd40, 4'd4);
      for (int n = 1; n <= 5; n++) tick();
      chk("t4_settled", settled, 1);
      chk("t4_level", code_level, 40);
      cnt40 = 0;
      cnt41 = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (code_level == 8'd40) cnt40++;
         if (code_level == 8'd41) cnt41++;
         chk("t4_code", code, therm(int'(code_level)));
      end
      chk("t4_cnt41", cnt41, 4);
      chk("t4_cnt40", cnt40, 12);

      // 5: freeze mid-ramp with retarget
      pulse_reset();
      set_tune(8'd64, 4'd0);
      for (int n = 1; n <= 3; n++) tick();
      chk("t5_pre_level", code_level, 24);
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_frz_level", code_level, 24);
         chk("t5_frz_code", code, therm(24));
      end
      set_tune(8'd48, 4'd0);
      chk("t5_frz_rt_level", code_level, 24);
      tick();
      chk("t5_frz_rt2_level", code_level, 24);
      freeze = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         tick();
         chk("t5_rel_level", code_level, 24 + 8 * n);
         chk("t5_rel_settled", settled, (n == 3) ? 1 : 0);
      end

      // 6: async reset mid-ramp
      pulse_reset();
      set_tune(8'd80, 4'd0);
      for (int n = 1; n <= 7; n++) tick();
      chk("t6_pre_level", code_level, 56);
      rst = 1'b1;
      #1;
      chk("t6_async_code", code, 0);
      chk("t6_async_level", code_level, 0);
      chk("t6_async_settled", settled, 0);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6_idle_level", code_level, 0);
         chk("t6_idle_settled", settled, 0);
      end

      // IDLE straight to TRACK at level 0 with half-LSB dither
      set_tune(8'd0, 4'd8);
      chk("t7_settled", settled, 1);
      chk("t7_k_level", code_level, 0);
      tick();
      chk("t7_d1_level", code_level, 0);
      tick();
      chk("t7_d2_level", code_level, 1);
      chk("t7_d2_code", code, therm(1));
      tick();
      chk("t7_d3_level", code_level, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
